// File: rtl/scenic_pkg.sv
// Shared types and defaults for the lane scatter sequencing stage.
package scenic_pkg;

    typedef enum logic [2:0] {IDLE, RUN, PAD, DRAIN, DONE} scatter_state_t;

    localparam int DEFAULT_NUM_LANES  = 15;
    localparam int DEFAULT_DATA_WIDTH = 8;

endpackage

// File: rtl/lane_scatter_ctrl_out_reg.sv
// Single-entry output register in front of the demux: holds data/sel until the
// selected lane is ready, then emits a one-hot write strobe for that lane.
module scatter_out_reg #(
    parameter int NUM_LANES  = 15,
    parameter int DATA_WIDTH = 8,
    parameter int SEL_W      = $clog2(NUM_LANES)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic [SEL_W-1:0]      load_sel,
    input  logic [NUM_LANES-1:0]  lane_ready,
    output logic [DATA_WIDTH-1:0] dmx_data,
    output logic [SEL_W-1:0]      dmx_sel,
    output logic [NUM_LANES-1:0]  lane_we,
    output logic                  pending,
    output logic                  fire
);

    assign fire = pending && lane_ready[dmx_sel];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dmx_data <= '0;
            dmx_sel  <= '0;
            pending  <= 1'b0;
        end else if (load) begin
            dmx_data <= load_data;
            dmx_sel  <= load_sel;
            pending  <= 1'b1;
        end else if (fire) begin
            pending  <= 1'b0;
        end
    end

    always_comb begin
        lane_we = '0;
        if (fire) lane_we[dmx_sel] = 1'b1;
    end

endmodule

// File: rtl/lane_scatter_ctrl.sv
// Round-robin byte scatter in front of the 1-to-N demux, with zero-padding of a
// short final row. Optional statistics outputs under LANE_SCATTER_STATS_EN.
module lane_scatter_ctrl
    import scenic_pkg::*;
#(
    parameter int NUM_LANES  = DEFAULT_NUM_LANES,
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int SEL_W      = $clog2(NUM_LANES)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_last,
    input  logic [NUM_LANES-1:0]  lane_ready,
    output logic [DATA_WIDTH-1:0] dmx_data,
    output logic [SEL_W-1:0]      dmx_sel,
    output logic [NUM_LANES-1:0]  lane_we,
    output logic                  busy,
    output logic                  done
`ifdef LANE_SCATTER_STATS_EN
    ,
    output logic [15:0]           frame_cnt,
    output logic [SEL_W-1:0]      pad_cnt
`endif
);

    scatter_state_t        state_q, state_d;
    logic [SEL_W-1:0]      ptr_q, ptr_d, ptr_next;
    logic                  last_lane;
    logic                  pending, fire, can_load;
    logic                  load, pad_load;
    logic [DATA_WIDTH-1:0] load_data;

    // A byte transfers when s_valid && s_ready; s_ready never depends on s_valid.
    assign can_load  = !pending || fire;
    assign last_lane = (ptr_q == SEL_W'(NUM_LANES - 1));
    assign ptr_next  = last_lane ? '0 : ptr_q + SEL_W'(1);
    assign busy      = (state_q != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        load      = 1'b0;
        pad_load  = 1'b0;
        load_data = '0;
        s_ready   = 1'b0;
        done      = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    ptr_d   = '0;
                end
            end
            RUN: begin
                s_ready = can_load;
                if (s_valid && can_load) begin
                    load      = 1'b1;
                    load_data = s_data;
                    ptr_d     = ptr_next;
                    if (s_last) state_d = last_lane ? DRAIN : PAD;
                end
            end
            PAD: begin
                // Zero bytes fill out the rest of the current row only.
                if (can_load) begin
                    load     = 1'b1;
                    pad_load = 1'b1;
                    ptr_d    = ptr_next;
                    if (last_lane) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (fire) state_d = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    scatter_out_reg #(
        .NUM_LANES (NUM_LANES),
        .DATA_WIDTH(DATA_WIDTH),
        .SEL_W     (SEL_W)
    ) u_out_reg (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .load_data (load_data),
        .load_sel  (ptr_q),
        .lane_ready(lane_ready),
        .dmx_data  (dmx_data),
        .dmx_sel   (dmx_sel),
        .lane_we   (lane_we),
        .pending   (pending),
        .fire      (fire)
    );

`ifdef LANE_SCATTER_STATS_EN
    logic [SEL_W-1:0] pad_acc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt <= '0;
            pad_cnt   <= '0;
            pad_acc   <= '0;
        end else begin
            if (state_q == IDLE && start) pad_acc <= '0;
            else if (pad_load)            pad_acc <= pad_acc + SEL_W'(1);
            if (state_q == DONE) begin
                pad_cnt <= pad_acc;
                if (frame_cnt != 16'hFFFF) frame_cnt <= frame_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_lane_scatter_ctrl.sv
// Self-checking bench for lane_scatter_ctrl: scoreboard of {sel, data} per lane write.
// Define LANE_SCATTER_STATS_EN to also check frame_cnt/pad_cnt.
module tb_lane_scatter_ctrl;
    import scenic_pkg::*;

    localparam int N  = 15;
    localparam int DW = 8;
    localparam int SW = 4;
    localparam int EW = SW + DW;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] s_data;
    logic          s_last;
    logic [N-1:0]  lane_ready;
    logic [DW-1:0] dmx_data;
    logic [SW-1:0] dmx_sel;
    logic [N-1:0]  lane_we;
    logic          busy;
    logic          done;
`ifdef LANE_SCATTER_STATS_EN
    logic [15:0]   frame_cnt;
    logic [SW-1:0] pad_cnt;
`endif

    lane_scatter_ctrl #(.NUM_LANES(N), .DATA_WIDTH(DW), .SEL_W(SW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .s_last    (s_last),
        .lane_ready(lane_ready),
        .dmx_data  (dmx_data),
        .dmx_sel   (dmx_sel),
        .lane_we   (lane_we),
        .busy      (busy),
        .done      (done)
`ifdef LANE_SCATTER_STATS_EN
        ,
        .frame_cnt (frame_cnt),
        .pad_cnt   (pad_cnt)
`endif
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int done_cnt = 0;
    int wr_cnt   = 0;
    int first_wr = 0;
    int last_wr  = 0;
    int last_pads = 0;
    int exp_frames = 0;
    logic [EW-1:0] exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        logic [EW-1:0] e;
        if (rst_n && done) done_cnt++;
        if (rst_n && lane_we != '0) begin
            check("we_onehot", 32'(lane_we), 32'(1) << dmx_sel);
            if (exp_q.size() == 0) begin
                check("unexpected_write", 32'(dmx_sel), 32'hFFFF);
            end else begin
                e = exp_q.pop_front();
                check("write_sel", 32'(dmx_sel), 32'(e[EW-1:DW]));
                check("write_data", 32'(dmx_data), 32'(e[DW-1:0]));
            end
            if (wr_cnt == 0) first_wr = cyc;
            last_wr = cyc;
            wr_cnt++;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic start_frame();
        @(posedge clk); #1;
        wr_cnt   = 0;
        done_cnt = 0;
        start    = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
    endtask

    task automatic send_byte(input logic [DW-1:0] d, input logic last);
        int t;
        t = 0;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        forever begin
            @(negedge clk);
            if (s_ready) break;
            t++;
            if (t > 200) begin
                check("s_ready_timeout", 32'd0, 32'd1);
                break;
            end
        end
        @(posedge clk); #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic send_frame(input int n, input logic [DW-1:0] base);
        int l;
        for (int i = 0; i < n; i++) exp_q.push_back({SW'(i % N), DW'(base + DW'(i))});
        l = (n - 1) % N;
        last_pads = N - 1 - l;
        for (int j = l + 1; j < N; j++) exp_q.push_back({SW'(j), DW'(0)});
        for (int i = 0; i < n; i++) send_byte(DW'(base + DW'(i)), (i == n - 1));
    endtask

    task automatic wait_done(input string tag);
        int t;
        t = 0;
        forever begin
            @(negedge clk);
            if (done) break;
            t++;
            if (t > 200) begin
                check({tag, "_done_timeout"}, 32'd0, 32'd1);
                break;
            end
        end
        exp_frames++;
        @(negedge clk);
        check({tag, "_busy_after_done"}, 32'(busy), 32'd0);
        check({tag, "_done_single_cycle"}, 32'(done), 32'd0);
        repeat (3) @(negedge clk);
        check({tag, "_done_count"}, 32'(done_cnt), 32'd1);
        check({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
`ifdef LANE_SCATTER_STATS_EN
        check({tag, "_frame_cnt"}, 32'(frame_cnt), 32'(exp_frames));
        check({tag, "_pad_cnt"}, 32'(pad_cnt), 32'(last_pads));
`endif
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_lane_we"}, 32'(lane_we), 32'd0);
        check({tag, "_dmx_data"}, 32'(dmx_data), 32'd0);
        check({tag, "_dmx_sel"}, 32'(dmx_sel), 32'd0);
        check({tag, "_s_ready"}, 32'(s_ready), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        rst_n      = 1'b0;
        start      = 1'b0;
        s_valid    = 1'b0;
        s_data     = '0;
        s_last     = 1'b0;
        lane_ready = '1;
        #1;
        check_reset_outputs("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Full row, back-to-back
        start_frame();
        send_frame(15, 8'h01);
        wait_done("full_row");
        check("full_row_wr_cnt", 32'(wr_cnt), 32'd15);
        check("full_row_consecutive", 32'(last_wr - first_wr), 32'd14);

        // Short frame with padding
        start_frame();
        send_frame(4, 8'hA0);
        wait_done("short");
        check("short_wr_cnt", 32'(wr_cnt), 32'd15);

        // Backpressure on lane 2
        lane_ready[2] = 1'b0;
        start_frame();
        fork
            send_frame(15, 8'h10);
            begin
                int t;
                t = 0;
                forever begin
                    @(negedge clk);
                    if (dmx_sel == SW'(2) && busy) break;
                    t++;
                    if (t > 100) begin
                        check("bp_reach_lane2", 32'(dmx_sel), 32'd2);
                        break;
                    end
                end
                for (int k = 0; k < 5; k++) begin
                    check("bp_sel_hold", 32'(dmx_sel), 32'd2);
                    check("bp_s_ready", 32'(s_ready), 32'd0);
                    check("bp_lane_we", 32'(lane_we), 32'd0);
                    @(negedge clk);
                end
                @(posedge clk); #1;
                lane_ready = '1;
                @(negedge clk);
                check("bp_release_we", 32'(lane_we), 32'h4);
                check("bp_release_data", 32'(dmx_data), 32'h12);
            end
        join
        wait_done("backpressure");
        check("bp_wr_cnt", 32'(wr_cnt), 32'd15);

        // Two rows, no padding
        start_frame();
        send_frame(30, 8'h40);
        wait_done("multi_row");
        check("multi_row_wr_cnt", 32'(wr_cnt), 32'd30);

        // s_valid in IDLE ignored
        @(posedge clk); #1;
        s_valid = 1'b1;
        s_data  = 8'hEE;
        repeat (3) begin
            @(negedge clk);
            check("idle_s_ready", 32'(s_ready), 32'd0);
            check("idle_busy", 32'(busy), 32'd0);
            check("idle_lane_we", 32'(lane_we), 32'd0);
        end
        @(posedge clk); #1;
        s_valid = 1'b0;

        // start during RUN ignored
        start_frame();
        fork
            send_frame(15, 8'h30);
            begin
                repeat (3) @(posedge clk);
                #1 start = 1'b1;
                repeat (3) @(posedge clk);
                #1 start = 1'b0;
            end
        join
        wait_done("start_in_run");

        // Reset mid-frame after byte 7
        start_frame();
        for (int i = 0; i < 6; i++) exp_q.push_back({SW'(i), DW'(8'h50 + DW'(i))});
        for (int i = 0; i < 7; i++) send_byte(DW'(8'h50 + DW'(i)), 1'b0);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_reset");
        repeat (2) @(negedge clk);
        check("mid_reset_queue", 32'(exp_q.size()), 32'd0);
        check("mid_reset_no_done", 32'(done_cnt), 32'd0);
        rst_n = 1'b1;
        exp_frames = 0;

        start_frame();
        send_frame(15, 8'h01);
        wait_done("after_reset");
        check("after_reset_consecutive", 32'(last_wr - first_wr), 32'd14);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
